// File: rtl/sram_bus_if.sv
// SRAM-like request/response bundle: req/wr/size/addr/wdata with addr_ok, data_ok, rdata.
// The master drives the request fields and the slave returns the acceptance and response.
interface sram_bus_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// 2:1 ibus/dbus arbiter onto one SRAM-like port with a single transaction outstanding; dbus has priority.
// The grant is made combinationally in IDLE, so a request can be accepted in the same cycle; the losing master is stalled until the arbiter returns to IDLE.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      rst,
    sram_bus_if.slave  ibus,
    sram_bus_if.slave  dbus,
    sram_bus_if.master mem,
    output logic      busy_o,
    output logic      owner_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic [SW-1:0] streak_q, streak_d;

    logic dbus_wins;
    logic grant;
    logic sel;
    logic req_out;
    logic resp;

    // ibus is forced through once dbus has won STARVE_LIMIT times in a row while ibus was waiting.
    assign dbus_wins = dbus.req && !(ibus.req && (streak_q == LIMIT));
    assign grant     = !rst && (state_q == S_IDLE) && (ibus.req || dbus.req);
    assign sel       = (state_q == S_IDLE) ? dbus_wins : owner_q;
    assign req_out   = grant || (!rst && (state_q == S_ADDR));

    assign mem.req   = req_out;
    assign mem.wr    = req_out && (sel ? dbus.wr : ibus.wr);
    assign mem.size  = req_out ? (sel ? dbus.size  : ibus.size)  : 2'b00;
    assign mem.addr  = req_out ? (sel ? dbus.addr  : ibus.addr)  : 32'h0;
    assign mem.wdata = req_out ? (sel ? dbus.wdata : ibus.wdata) : 32'h0;

    assign ibus.addr_ok = req_out && !sel && mem.addr_ok;
    assign dbus.addr_ok = req_out &&  sel && mem.addr_ok;

    // A data_ok outside DATA belongs to no live transaction and is dropped.
    assign resp         = !rst && (state_q == S_DATA) && mem.data_ok;
    assign ibus.data_ok = resp && !owner_q;
    assign dbus.data_ok = resp &&  owner_q;
    assign ibus.rdata   = rst ? 32'h0 : mem.rdata;
    assign dbus.rdata   = rst ? 32'h0 : mem.rdata;

    assign busy_o  = (state_q != S_IDLE);
    assign owner_o = owner_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    owner_d = sel;
                    state_d = mem.addr_ok ? S_DATA : S_ADDR;
                    if (sel && ibus.req) begin
                        streak_d = (streak_q == LIMIT) ? LIMIT : streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                end
            end
            S_ADDR: begin
                if (mem.addr_ok) state_d = S_DATA;
            end
            S_DATA: begin
                if (mem.data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end
endmodule
